onehot_rr_arbiter: RTL and testbench



---
 rtl/onehot_rr_arbiter_pkg.sv | 30 +++
 rtl/onehot_rr_arbiter_pick.sv | 59 +++++
 rtl/onehot_rr_arbiter.sv | 119 +++++++++++
 tb/tb_onehot_rr_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/onehot_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_rr_arbiter_pkg
// Description : Shared definitions for the one-hot round-robin arbiter.
//               - clog2(): ceiling log2 for deriving the grant index width
//               - arb_state_t: IDLE / BUSY arbiter state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_rr_arbiter_pkg;

    // Ceiling log2, minimum result 1 so that an index port is never zero-width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage : onehot_rr_arbiter_pkg
`default_nettype wire

// File: rtl/onehot_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request scanning from ptr upward, wrapping modulo N_REQ.
//               Implemented as a doubled request vector rotated by ptr, a
//               fixed-priority find-first-set, then rotation back.
// Ports       : req      - request vector
//               ptr      - highest-priority requester index
//               pick     - one-hot picked requester (all-zero if none)
//               pick_idx - binary index of pick (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import onehot_rr_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int W_IDX = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W_IDX-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [W_IDX-1:0] pick_idx
);

    localparam logic [W_IDX:0] C_N = (W_IDX + 1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   win;
    logic [W_IDX-1:0]   off;
    logic [W_IDX:0]     sum;
    logic               found;

    always_comb begin
        dbl   = {req, req};
        // Bit 0 of win is requester ptr, bit 1 is ptr+1, ... wrapping.
        win   = N_REQ'(dbl >> ptr);
        found = |win;
        off   = '0;
        // Downward scan so the lowest set bit is the last assignment.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (win[i]) begin
                off = W_IDX'(i);
            end
        end
        // Rotate back: absolute index = (ptr + off) mod N_REQ.
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= C_N) begin
            sum = sum - C_N;
        end
        pick_idx = found ? W_IDX'(sum) : '0;
        pick     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick[i] = found && (pick_idx == W_IDX'(i));
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onehot_rr_arbiter
// Description : Round-robin arbiter with a registered one-hot grant held for
//               a whole transaction. On done the grant hands off to the next
//               requester in the same edge (owner excluded), or goes idle.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               req       - per-requester request level
//               done      - owner's transaction completes (BUSY only)
//               gnt       - registered one-hot / zero grant
//               gnt_valid - registered, equals |gnt
//               gnt_idx   - registered binary index of grant, 0 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter
    import onehot_rr_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int W_IDX = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [W_IDX-1:0] gnt_idx
);

    localparam logic [W_IDX-1:0] C_LAST = W_IDX'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [W_IDX-1:0] ptr_q,   ptr_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [W_IDX-1:0] idx_q,   idx_d;

    logic             handoff;
    logic [W_IDX-1:0] ptr_next;
    logic [W_IDX-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick;
    logic [W_IDX-1:0] pick_idx;
    logic             pick_any;

    // On handoff the picker already sees the advanced pointer and a request
    // vector with the finishing owner masked out, so the owner cannot re-win.
    always_comb begin
        handoff  = (state_q == ST_BUSY) && done;
        ptr_next = (idx_q == C_LAST) ? '0 : idx_q + 1'b1;
        pick_ptr = handoff ? ptr_next : ptr_q;
        pick_req = handoff ? (req & ~gnt_q) : req;
    end

    rr_pick #(
        .N_REQ    (N_REQ)
    ) u_pick (
        .req      (pick_req),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign pick_any = |pick;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick;
                    idx_d   = pick_idx;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    ptr_d = ptr_next;
                    if (pick_any) begin
                        gnt_d = pick;
                        idx_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == ST_BUSY);
    assign gnt_idx   = idx_q;

endmodule : onehot_rr_arbiter
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_rr_arbiter
// Description : Self-checking bench for onehot_rr_arbiter (N_REQ = 4).
//               Table-driven vectors plus hand sequences for reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_arbiter;

    localparam int N = 4;
    localparam int NV = 22;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_idx;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl [NV];

    onehot_rr_arbiter #(
        .N_REQ     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] eg, input logic ev, input logic [1:0] ei);
        chk({name, ".gnt"},       32'(gnt),       32'(eg));
        chk({name, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
        chk({name, ".gnt_idx"},   32'(gnt_idx),   32'(ei));
    endtask

    // Structural invariants, every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
        end
    end

    initial begin
        checks   = 0;
        failures = 0;

        // Reset/idle through hold, rotation, skip/wrap, sole requester,
        // done-while-idle and a late request joining a handoff.
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b0100, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{4'b0100, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[3]  = '{4'b0100, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[4]  = '{4'b0100, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[10] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[11] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[13] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[14] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1};
        tbl[15] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[17] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[18] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[19] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[20] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[21] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};

        // Reset held with all requests high: outputs must stay zero.
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        #1;
        chk_out("reset_async", 4'b0000, 1'b0, 2'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_out("reset_held", 4'b0000, 1'b0, 2'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            if (v != 0) @(negedge clk);
            req  = tbl[v].req;
            done = tbl[v].done;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].valid, tbl[v].idx);
        end

        // Mid-transaction reset while owner 2 holds the grant.
        @(negedge clk);
        chk("pre_reset_gnt", 32'(gnt), 32'h4);
        done = 1'b0;
        rst  = 1'b1;
        #1;
        chk_out("midrst_async", 4'b0000, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        chk_out("midrst_held", 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0110;
        @(posedge clk);
        #1;
        chk_out("midrst_ptr0", 4'b0010, 1'b1, 2'd1);

        // Request arriving in the done cycle of the sole other requester.
        @(negedge clk);
        req  = 4'b1010;
        done = 1'b1;
        @(posedge clk);
        #1;
        chk_out("late_req", 4'b1000, 1'b1, 2'd3);

        @(negedge clk);
        req  = 4'b0000;
        done = 1'b0;
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_onehot_rr_arbiter
`default_nettype wire
